matmul_scheduler: RTL and testbench

MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

---
 rtl/matmul_scheduler.sv | 162 ++++++++++++++++
 tb/tb_matmul_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/matmul_scheduler.sv
// Row-major operand scheduler for an NxN matmul: fetches A row / B column from BRAM,
// hands operand pairs to the compute unit and bounds the number of unretired ops.
module matmul_scheduler #(
  parameter int MAX_SIZE     = 32,
  parameter int RD_LAT       = 2,
  parameter int MAX_INFLIGHT = 4,
  localparam int IW = $clog2(MAX_SIZE),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          inter_refclk,
  input  logic          rst_n,
  input  logic          load_complete,
  input  logic [5:0]    n_cfg,
  output logic          rd_en,
  output logic [IW-1:0] rd_row,
  output logic [IW-1:0] rd_col,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [IW-1:0] op_i,
  output logic [IW-1:0] op_j,
  input  logic          res_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    n_q, n_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          lc_q, arm_q, arm_d;
  logic          rd_en_q, rd_en_d, op_valid_q, op_valid_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [IW-1:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [IW-1:0] op_i_q, op_i_d, op_j_q, op_j_d;
  logic          start, hs, spurious, last_col, last_row;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    inflight_d = inflight_q;
    spurious   = 1'b0;
    // arm_q blocks a level already high at reset release from looking like an edge
    arm_d      = arm_q | ~load_complete;
    start      = (state_q == IDLE) && load_complete && !lc_q && arm_q;
    hs         = (state_q == ISSUE) && op_ready;
    last_col   = 6'(j_q) == n_q - 6'd1;
    last_row   = 6'(i_q) == n_q - 6'd1;

    if (hs && !res_valid)
      inflight_d = inflight_q + CW'(1);
    else if (res_valid && inflight_q == '0) begin
      spurious = 1'b1;
      if (hs) inflight_d = CW'(1);
    end else if (res_valid && !hs)
      inflight_d = inflight_q - CW'(1);

    case (state_q)
      IDLE: if (start) begin
        if (n_cfg == 6'd0 || 32'(n_cfg) > MAX_SIZE) err_d = 1'b1;
        else begin
          n_d     = n_cfg;
          i_d     = '0;
          j_d     = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: if (inflight_q < CW'(MAX_INFLIGHT)) begin
        state_d = WAIT;
        wcnt_d  = 3'(RD_LAT - 2);
      end
      WAIT: begin
        if (wcnt_q == 3'd0) state_d = ISSUE;
        else wcnt_d = wcnt_q - 3'd1;
      end
      ISSUE: if (op_ready) begin
        if (last_col) begin
          j_d     = '0;
          i_d     = i_q + IW'(1);
          state_d = last_row ? DRAIN : FETCH;
        end else begin
          j_d     = j_q + IW'(1);
          state_d = FETCH;
        end
      end
      DRAIN: if (inflight_d == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (spurious) err_d = 1'b1;

    // outputs registered from the next state so they line up with it
    rd_en_d    = (state_d == FETCH) && (inflight_d < CW'(MAX_INFLIGHT));
    rd_row_d   = rd_en_d ? i_d : rd_row_q;
    rd_col_d   = rd_en_d ? j_d : rd_col_q;
    op_valid_d = (state_d == ISSUE);
    op_i_d     = op_valid_d ? i_d : op_i_q;
    op_j_d     = op_valid_d ? j_d : op_j_q;
    busy_d     = state_d inside {FETCH, WAIT, ISSUE, DRAIN};
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      inflight_q <= '0;
      wcnt_q     <= '0;
      lc_q       <= 1'b0;
      arm_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      op_valid_q <= 1'b0;
      op_i_q     <= '0;
      op_j_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      inflight_q <= inflight_d;
      wcnt_q     <= wcnt_d;
      lc_q       <= load_complete;
      arm_q      <= arm_d;
      rd_en_q    <= rd_en_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      op_valid_q <= op_valid_d;
      op_i_q     <= op_i_d;
      op_j_q     <= op_j_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_row   = rd_row_q;
  assign rd_col   = rd_col_q;
  assign op_valid = op_valid_q;
  assign op_i     = op_i_q;
  assign op_j     = op_j_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Bench for matmul_scheduler: directed scenarios plus randomized handshake timing,
// checked against a transaction-level model of the operand schedule.
module tb_matmul_scheduler;
  localparam int MAX_SIZE = 32, RD_LAT = 2, MAX_INFLIGHT = 4;
  localparam int IW = $clog2(MAX_SIZE);

  logic          clk = 1'b0, rst_n = 1'b0, load_complete = 1'b0;
  logic          op_ready = 1'b0, res_valid = 1'b0;
  logic [5:0]    n_cfg = '0;
  logic          rd_en, op_valid, busy, done, err;
  logic [IW-1:0] rd_row, rd_col, op_i, op_j;
  int checks = 0, failures = 0;

  matmul_scheduler #(.MAX_SIZE(MAX_SIZE), .RD_LAT(RD_LAT), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .inter_refclk(clk), .rst_n(rst_n), .load_complete(load_complete), .n_cfg(n_cfg),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .op_valid(op_valid),
    .op_ready(op_ready), .op_i(op_i), .op_j(op_j), .res_valid(res_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full schedule of n*n ops. hold>0: no retirements until hold ops issued, then 6 idle
  // cycles. coinc: retire only alongside a handshake with >=2 outstanding, then drain.
  task automatic run_sched(input int n, input int p_rdy, input int p_rv, input int hold,
                           input bit coinc);
    int ei = 0, ej = 0, outst = 0, nrd = 0, nops = 0, ndone = 0, cyc = 0;
    int rd_cyc = -100, hold_cyc = -1, resume_at = -1, zero_cyc = -1, rdy_low = 0;
    bit pend = 0, hs, rv, first = 1;
    logic [IW-1:0] pi = '0, pj = '0, lr = '0, lc = '0;
    n_cfg = 6'(n); op_ready = 0; res_valid = 0;
    load_complete = 0; tick(); load_complete = 1;
    while (ndone == 0 && cyc < 20000) begin
      tick(); cyc++;
      if (first) begin chk("start_busy_err", {busy, err}, 2'b10); first = 0; end
      if (cyc == resume_at) chk("resume_rd_en", rd_en, 1);
      else if (hold > 0 && hold_cyc >= 0 && resume_at < 0 && cyc > hold_cyc)
        chk("stall_rd_en", rd_en, 0);
      if (rd_en) begin
        nrd++; rd_cyc = cyc; lr = ei[IW-1:0]; lc = ej[IW-1:0];
        chk("rd_addr", {rd_row, rd_col}, {ei[IW-1:0], ej[IW-1:0]});
        chk("rd_cap", outst < MAX_INFLIGHT, 1);
      end else if (nrd > 0) chk("rd_addr_hold", {rd_row, rd_col}, {lr, lc});
      if (pend) chk("op_hold", {op_valid, op_i, op_j}, {1'b1, pi, pj});
      else if (op_valid) chk("rd_to_valid", cyc - rd_cyc, RD_LAT);
      if (done) begin
        ndone++;
        chk("done_timing", cyc, zero_cyc + 1);
        chk("done_busy", busy, 0);
      end
      if (nops == 0 && op_valid && rdy_low < 10) begin
        op_ready = 0; rdy_low++;
        chk("stall_no_rd", rd_en, 0);
      end else op_ready = ($urandom_range(99) < p_rdy);
      hs = op_valid && op_ready;
      if (hs) begin
        chk("op_idx", {op_i, op_j}, {ei[IW-1:0], ej[IW-1:0]});
        nops++;
        if (ej == n - 1) begin ej = 0; ei++; end else ej++;
      end
      if (hold > 0 && nops >= hold && hold_cyc < 0) hold_cyc = cyc;
      if (coinc) rv = outst > 0 && (hs ? outst >= 2 : nops == n * n);
      else rv = outst > 0 && (hold == 0 || (hold_cyc >= 0 && cyc >= hold_cyc + 6))
                && ($urandom_range(99) < p_rv);
      if (rv && hold > 0 && resume_at < 0 && outst == MAX_INFLIGHT) resume_at = cyc + 1;
      res_valid = rv;
      outst = outst + (hs ? 1 : 0) - (rv ? 1 : 0);
      if (rv && outst == 0 && nops == n * n) zero_cyc = cyc;
      pend = op_valid && !op_ready;
      if (op_valid) begin pi = op_i; pj = op_j; end
    end
    op_ready = 0; res_valid = 0;
    chk("sched_done", ndone, 1);
    chk("op_count", nops, n * n);
    chk("rd_count", nrd, n * n);
    tick();
    chk("post_done", {done, busy}, 2'b00);
  endtask

  initial begin
    int nhs, t;
    bit found, prev_hs;
    logic [5:0] bad [2];
    bad[0] = 6'd0; bad[1] = 6'd33;

    #12;
    chk("rst_ctrl", {rd_en, op_valid, busy, done, err}, 0);
    chk("rst_addr", {rd_row, rd_col, op_i, op_j}, 0);
    tick(); rst_n = 1; tick();

    // retirement with nothing outstanding
    res_valid = 1; tick(); res_valid = 0;
    chk("spurious_err", err, 1);
    chk("spurious_busy", busy, 0);

    run_sched(2, 100, 100, 0, 0);
    run_sched(3, 100, 100, 4, 0);
    run_sched(2, 100, 0, 0, 1);

    foreach (bad[b]) begin
      load_complete = 0; n_cfg = bad[b]; tick(); load_complete = 1;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("bad_n_idle", {busy, rd_en}, 2'b00);
      end
      chk("bad_n_err", err, 1);
    end
    run_sched(1, 100, 100, 0, 0);
    run_sched(32, 100, 100, 0, 0);

    // reset while the 3rd op of an n=2 run is being offered
    n_cfg = 2; load_complete = 0; tick(); load_complete = 1;
    nhs = 0; t = 0; found = 0; prev_hs = 0;
    while (!found && t < 100) begin
      tick(); t++;
      if (op_valid && nhs == 2) found = 1;
      else begin
        op_ready = 1; res_valid = prev_hs; prev_hs = op_valid;
        if (op_valid) nhs++;
      end
    end
    chk("mid_found", found, 1);
    op_ready = 0; res_valid = 0; rst_n = 0; #1;
    chk("mid_rst_ctrl", {rd_en, op_valid, busy, done, err}, 0);
    chk("mid_rst_addr", {rd_row, rd_col, op_i, op_j}, 0);
    tick(); tick(); rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("no_restart", {busy, done, rd_en}, 3'b000);
    end
    run_sched(2, 100, 100, 0, 0);

    for (int k = 0; k < 6; k++)
      run_sched($urandom_range(5, 1), $urandom_range(100, 30), $urandom_range(100, 20), 0,
                k[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
